// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// Strobe polarity is folded into ENA/DISENA so callers stay polarity-agnostic.
package sram_arb_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_SWITCH = 2'd2
  } arb_state_t;

  function automatic logic ENA(input bit act_low);
    return act_low ? 1'b0 : 1'b1;
  endfunction

  function automatic logic DISENA(input bit act_low);
    return act_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Read tag delay line: one {valid,id} slot per cycle of SRAM read latency.
// The last slot tells the top which port owns the s_qdata being sampled.
module sram_rd_tag_pipe
  import sram_arb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic push_id,
  output logic pop_valid,
  output logic pop_id,
  output logic pending
);

  logic [RD_LAT-1:0] vld;
  logic [RD_LAT-1:0] ids;

  // shift tags one slot per cycle; reset drops reads in flight
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld <= '0;
      ids <= '0;
    end else begin
      vld[0] <= push;
      ids[0] <= push_id;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        ids[i] <= ids[i-1];
      end
    end
  end

  assign pop_valid = vld[RD_LAT-1];
  assign pop_id    = ids[RD_LAT-1];
  assign pending   = |vld;

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of one synchronous SRAM port.
// Burst lock keeps ownership; the burst cap forces a hand-over.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 16,
  parameter bit ACT_LOW   = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  input  logic [DATA_W-1:0] s_qdata,
  output logic              s_clk,
  output logic              s_cen,
  output logic              s_wen,
  output logic              s_oen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_ddata,
  output logic [1:0]        owner,
  output logic              busy
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CAP    = CW'(MAX_BURST);
  localparam logic [CW-1:0] CAP_M1 = CW'(MAX_BURST - 1);

  arb_state_t        state, state_nx;
  logic              owner_id, owner_id_nx;
  logic              rr_ptr, rr_ptr_nx;
  logic [CW-1:0]     burst_cnt, burst_cnt_nx;
  logic [1:0]        req, lock, gnt;
  logic              own_req, oth_req, own_lock;
  logic              win, acc, acc_id;
  logic              cap_now, cap_hit;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              pop_valid, pop_id, pending;

  assign req      = {r1_req, r1_req ? 1'b0 : 1'b0} | {1'b0, r0_req};
  assign lock     = {r1_lock, r0_lock};
  assign own_req  = req[owner_id];
  assign oth_req  = req[~owner_id];
  assign own_lock = lock[owner_id];
  assign win      = (&req) ? rr_ptr : req[1];
  assign cap_now  = (burst_cnt == CAP);
  assign acc      = |gnt;
  assign acc_id   = gnt[1];
  assign cap_hit  = acc && (burst_cnt == CAP_M1);

  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];
  assign s_clk  = clk;
  assign owner  = {state == ST_OWN, owner_id};
  assign busy   = pending | owner[1];

  assign cmd_we    = acc_id ? r1_we    : r0_we;
  assign cmd_addr  = acc_id ? r1_addr  : r0_addr;
  assign cmd_wdata = acc_id ? r1_wdata : r0_wdata;

  // FSM state, owner, round-robin pointer and burst counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      owner_id  <= 1'b0;
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      owner_id  <= owner_id_nx;
      rr_ptr    <= rr_ptr_nx;
      burst_cnt <= burst_cnt_nx;
    end
  end

  // next-state: hand over on release, lock drop or cap while other waits
  always_comb begin
    state_nx     = state;
    owner_id_nx  = owner_id;
    rr_ptr_nx    = rr_ptr;
    burst_cnt_nx = burst_cnt;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nx     = ST_OWN;
          owner_id_nx  = win;
          rr_ptr_nx    = ~win;
          burst_cnt_nx = CW'(1);
        end
      end
      ST_OWN: begin
        if (acc && !cap_now)
          burst_cnt_nx = burst_cnt + CW'(1);
        if (!(|req))
          state_nx = ST_IDLE;
        else if (oth_req &&
                 (!own_req || (acc && !own_lock) ||
                  cap_now || cap_hit))
          state_nx = ST_SWITCH;
      end
      ST_SWITCH: begin
        state_nx     = ST_OWN;
        owner_id_nx  = ~owner_id;
        rr_ptr_nx    = owner_id;
        burst_cnt_nx = '0;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // grant: IDLE winner, or owner unless capped with the other waiting
  always_comb begin
    gnt = '0;
    unique case (state)
      ST_IDLE:
        if (|req) gnt[win] = 1'b1;
      ST_OWN:
        if (own_req && !(cap_now && oth_req))
          gnt[owner_id] = 1'b1;
      default: gnt = '0;
    endcase
  end

  // SRAM pin registers: strobes pulse per accept, addr/data hold
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s_cen   <= DISENA(ACT_LOW);
      s_wen   <= DISENA(ACT_LOW);
      s_oen   <= DISENA(ACT_LOW);
      s_addr  <= '0;
      s_ddata <= '0;
    end else if (acc) begin
      s_cen  <= ENA(ACT_LOW);
      s_wen  <= cmd_we ? ENA(ACT_LOW) : DISENA(ACT_LOW);
      s_oen  <= cmd_we ? DISENA(ACT_LOW) : ENA(ACT_LOW);
      s_addr <= cmd_addr;
      if (cmd_we) s_ddata <= cmd_wdata;
    end else begin
      s_cen <= DISENA(ACT_LOW);
      s_wen <= DISENA(ACT_LOW);
      s_oen <= DISENA(ACT_LOW);
    end
  end

  sram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (acc && !cmd_we),
    .push_id   (acc_id),
    .pop_valid (pop_valid),
    .pop_id    (pop_id),
    .pending   (pending)
  );

  // read return: capture s_qdata for the tagged port
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= pop_valid && !pop_id;
      r1_rvalid <= pop_valid && pop_id;
      if (pop_valid && !pop_id) r0_rdata <= s_qdata;
      if (pop_valid && pop_id)  r1_rdata <= s_qdata;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter with a behavioural SRAM.
// Expected read data is queued at accept and popped on rvalid.
module tb_sram_port_arbiter;

  logic       clk;
  logic       reset_n;
  logic       r0_req, r0_we, r0_lock;
  logic [9:0] r0_addr;
  logic [7:0] r0_wdata;
  logic       r0_gnt, r0_rvalid;
  logic [7:0] r0_rdata;
  logic       r1_req, r1_we, r1_lock;
  logic [9:0] r1_addr;
  logic [7:0] r1_wdata;
  logic       r1_gnt, r1_rvalid;
  logic [7:0] r1_rdata;
  logic [7:0] s_qdata;
  logic       s_clk, s_cen, s_wen, s_oen;
  logic [9:0] s_addr;
  logic [7:0] s_ddata;
  logic [1:0] owner;
  logic       busy;

  sram_port_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_lock   (r0_lock),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_lock   (r1_lock),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .s_qdata   (s_qdata),
    .s_clk     (s_clk),
    .s_cen     (s_cen),
    .s_wen     (s_wen),
    .s_oen     (s_oen),
    .s_addr    (s_addr),
    .s_ddata   (s_ddata),
    .owner     (owner),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural active-low SRAM, one cycle after the pins
  logic [7:0] mem [0:1023];
  logic [7:0] q;
  assign s_qdata = q;

  always @(posedge clk) begin
    if (s_cen == 1'b0) begin
      if (s_wen == 1'b0) mem[s_addr] = s_ddata;
      else if (s_oen == 1'b0) q <= mem[s_addr];
    end
  end

  function automatic logic [7:0] pat(input logic [9:0] a);
    return a[7:0] ^ 8'hC3;
  endfunction

  int n_chk = 0;
  int n_fail = 0;
  int n_r0v = 0;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int gtr [$];
  bit rec = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  // monitor: grant trace and read-data scoreboard
  always @(negedge clk) begin
    if (rec) gtr.push_back(int'({r1_gnt, r0_gnt}));
    if (r0_rvalid) begin
      n_r0v++;
      if (q0.size() == 0)
        chk("r0_rvalid_unexpected", r0_rvalid, 0);
      else
        chk("r0_rdata", r0_rdata, q0.pop_front());
    end
    if (r1_rvalid) begin
      if (q1.size() == 0)
        chk("r1_rvalid_unexpected", r1_rvalid, 0);
      else
        chk("r1_rdata", r1_rdata, q1.pop_front());
    end
  end

  task automatic drive(input int p, input bit rq,
                       input bit we, input bit lk,
                       input logic [9:0] a,
                       input logic [7:0] d);
    if (p == 0) begin
      r0_req = rq; r0_we = we; r0_lock = lk;
      r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = rq; r1_we = we; r1_lock = lk;
      r1_addr = a; r1_wdata = d;
    end
  endtask

  // request until granted; queue expected read data at accept
  task automatic issue(input int p, input bit we,
                       input bit lk, input logic [9:0] a,
                       input logic [7:0] d,
                       input logic [7:0] e);
    int cyc;
    cyc = 0;
    drive(p, 1'b1, we, lk, a, d);
    @(negedge clk);
    while (!(p == 0 ? r0_gnt : r1_gnt) && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 64)
      chk("gnt_timeout", p == 0 ? r0_gnt : r1_gnt, 1);
    @(posedge clk);
    #1;
    if (!we) begin
      if (p == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    drive(p, 1'b0, we, 1'b0, a, d);
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 10'h0, 8'h0);
    drive(1, 1'b0, 1'b0, 1'b0, 10'h0, 8'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    for (int i = 0; i < 1024; i++) mem[i] = pat(10'(i));
    q = 8'h00;
    do_reset();

    // T1: reset mid-burst with two reads in flight
    drive(0, 1'b1, 1'b0, 1'b1, 10'h010, 8'h00);
    @(negedge clk) chk("t1_gnt_a", r0_gnt, 1);
    @(posedge clk) #1 r0_addr = 10'h011;
    @(negedge clk) chk("t1_gnt_b", r0_gnt, 1);
    @(posedge clk) #1;
    reset_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 10'h0, 8'h0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_cen", s_cen, 1);
    chk("t1_wen", s_wen, 1);
    chk("t1_oen", s_oen, 1);
    chk("t1_addr", s_addr, 0);
    chk("t1_busy", busy, 0);
    @(posedge clk) #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_rvalid", {r1_rvalid, r0_rvalid}, 0);
      chk("t1_owner", owner, 0);
    end

    // T2: single read, data two edges after the pins
    do_reset();
    mem[10'h155] = 8'hA5;
    drive(0, 1'b1, 1'b0, 1'b0, 10'h155, 8'h00);
    @(negedge clk) chk("t2_gnt", r0_gnt, 1);
    @(posedge clk) #1;
    q0.push_back(8'hA5);
    drive(0, 1'b0, 1'b0, 1'b0, 10'h155, 8'h00);
    @(negedge clk);
    chk("t2_oen", s_oen, 0);
    chk("t2_cen", s_cen, 0);
    chk("t2_wen", s_wen, 1);
    chk("t2_addr", s_addr, 10'h155);
    chk("t2_rv_n0", r0_rvalid, 0);
    @(negedge clk) chk("t2_rv_n1", r0_rvalid, 0);
    @(negedge clk) chk("t2_rv_n2", r0_rvalid, 1);
    chk("t2_rdata", r0_rdata, 8'hA5);
    @(negedge clk) chk("t2_rv_n3", r0_rvalid, 0);
    chk("t2_hold", r0_rdata, 8'hA5);

    // T3: contention from IDLE, r0 first, hand-over to r1
    do_reset();
    gtr.delete();
    rec = 1'b1;
    fork
      issue(0, 1'b0, 1'b0, 10'h001, 8'h0, pat(10'h001));
      issue(1, 1'b0, 1'b0, 10'h002, 8'h0, pat(10'h002));
    join
    rec = 1'b0;
    chk("t3_len", gtr.size(), 4);
    if (gtr.size() >= 4) begin
      chk("t3_g0", gtr[0], 1);
      chk("t3_g1", gtr[1], 0);
      chk("t3_g2", gtr[2], 0);
      chk("t3_g3", gtr[3], 2);
    end
    repeat (4) @(posedge clk);

    // T4: burst cap of 16 with r1 waiting
    do_reset();
    gtr.delete();
    rec = 1'b1;
    fork
      for (int k = 0; k < 17; k++)
        issue(0, 1'b1, 1'b1, 10'(10'h100 + k),
              8'(k), 8'h0);
      issue(1, 1'b0, 1'b0, 10'h020, 8'h0, pat(10'h020));
    join
    rec = 1'b0;
    chk("t4_len", gtr.size() >= 18, 1);
    if (gtr.size() >= 18) begin
      for (int k = 0; k < 16; k++)
        chk("t4_r0", gtr[k], 1);
      chk("t4_dead", gtr[16], 0);
      chk("t4_r1", gtr[17], 2);
    end
    repeat (4) @(posedge clk);

    // T5: r0 writes, r1 reads it back; r0 sees no rvalid
    do_reset();
    n0 = n_r0v;
    issue(0, 1'b1, 1'b0, 10'h3FF, 8'h5A, 8'h0);
    @(negedge clk);
    chk("t5_wen", s_wen, 0);
    chk("t5_ddata", s_ddata, 8'h5A);
    chk("t5_addr", s_addr, 10'h3FF);
    issue(1, 1'b0, 1'b0, 10'h3FF, 8'h0, 8'h5A);
    repeat (6) @(posedge clk);
    chk("t5_r0_quiet", n_r0v - n0, 0);

    // T6: back-to-back W/R pairs, no bubbles
    do_reset();
    gtr.delete();
    rec = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        issue(0, 1'b1, 1'b1, 10'(10'h040 + i / 2),
              8'(8'h90 + i), 8'h0);
      else
        issue(0, 1'b0, 1'b1, 10'(10'h040 + i / 2),
              8'h0, 8'(8'h90 + i - 1));
    end
    rec = 1'b0;
    chk("t6_len", gtr.size(), 8);
    for (int i = 0; i < 8 && i < gtr.size(); i++)
      chk("t6_gnt", gtr[i], 1);

    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);
    chk("end_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
